// File: rtl/exmem_pkg.sv
// Shared types and widths for the EX/MEM pipeline stage.
package exmem_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Control bits carried from EX into MEM.
    typedef struct packed {
        logic wreg;
        logic m2reg;
        logic wmem;
    } exmem_ctrl_t;

    // Packed payload layout: {ctrl, dest_reg, alu_result, store_data}.
    function automatic int payload_w(input int data_w, input int reg_addr_w);
        return $bits(exmem_ctrl_t) + reg_addr_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// The main entry drives the outputs. The skid entry absorbs the one beat
// that arrives while the main entry is stalled. in_ready depends only on
// registered state, so out_ready never reaches the input side combinationally.
module pipe_skid_buffer #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic                 main_valid_q, main_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [PAYLOAD_W-1:0] main_data_q, main_data_d;
    logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;
    logic                 in_fire;
    logic                 out_fire;

    // in_ready is held low while reset is asserted.
    assign in_ready  = !skid_valid_q && !reset;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid_q && out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

    // Next-state: flush beats every transfer; otherwise fill main first, spill to skid.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_valid_q && !out_fire) begin
            // Main is stalled: an arriving beat lands in the skid entry.
            if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (skid_valid_q) begin
            // Main is empty or leaving: refill it from skid (no input possible).
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else begin
            // Main is empty or leaving with skid empty: input goes straight to main.
            main_valid_d = in_fire;
            if (in_fire) begin
                main_data_d = in_data;
            end
        end
    end

    // State registers; everything clears on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/exmem_pipeline_stage.sv
// EX/MEM pipeline stage: packs EX results into a skid buffer and presents
// them to MEM with write enables qualified by out_valid.
// Optional macro EXMEM_PERF_CNT_EN adds stall/bubble cycle counters.
module exmem_pipeline_stage
    import exmem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  ewreg,
    input  logic                  em2reg,
    input  logic                  ewmem,
    input  logic [REG_ADDR_W-1:0] edest_reg,
    input  logic [DATA_W-1:0]     r,
    input  logic [DATA_W-1:0]     eqb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  mwreg,
    output logic                  mm2reg,
    output logic                  mwmem,
    output logic [REG_ADDR_W-1:0] mdest_reg,
    output logic [DATA_W-1:0]     mr,
    output logic [DATA_W-1:0]     mqb
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           bubble_cycles
`endif
);

    localparam int PW = payload_w(DATA_W, REG_ADDR_W);

    exmem_ctrl_t   in_ctrl;
    exmem_ctrl_t   out_ctrl;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    assign in_ctrl    = '{wreg: ewreg, m2reg: em2reg, wmem: ewmem};
    assign in_payload = {in_ctrl, edest_reg, r, eqb};

    pipe_skid_buffer #(
        .PAYLOAD_W(PW)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign {out_ctrl, mdest_reg, mr, mqb} = out_payload;

    // Stale payload after a flush must never write the register file or memory.
    assign mwreg  = out_ctrl.wreg && out_valid;
    assign mwmem  = out_ctrl.wmem && out_valid;
    assign mm2reg = out_ctrl.m2reg;

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;

    // Counters wrap naturally; flush does not touch them.
    always_comb begin
        stall_d  = stall_q + 32'(out_valid && !out_ready);
        bubble_d = bubble_q + 32'(!out_valid && !reset);
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_exmem_pipeline_stage.sv
// Self-checking bench for exmem_pipeline_stage (default and 64/6-bit builds).
module tb_exmem_pipeline_stage;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  dest;
        logic [31:0] r;
        logic [31:0] qb;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ewreg = 1'b0, em2reg = 1'b0, ewmem = 1'b0;
    logic [4:0]  edest_reg = '0;
    logic [31:0] r = '0, eqb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        mwreg, mm2reg, mwmem;
    logic [4:0]  mdest_reg;
    logic [31:0] mr, mqb;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [5:0]  w_edest = '0;
    logic [63:0] w_r = '0, w_eqb = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b0;
    logic        w_mwreg, w_mm2reg, w_mwmem;
    logic [5:0]  w_mdest;
    logic [63:0] w_mr, w_mqb;

    int errors = 0;
    int checks = 0;

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] stall_cycles, bubble_cycles;
    logic [31:0] w_stall, w_bubble;
`endif

    always #5 clock = ~clock;

    exmem_pipeline_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .edest_reg(edest_reg), .r(r), .eqb(eqb),
        .out_valid(out_valid), .out_ready(out_ready),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .mdest_reg(mdest_reg), .mr(mr), .mqb(mqb)
`ifdef EXMEM_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
    );

    exmem_pipeline_stage #(.DATA_W(64), .REG_ADDR_W(6)) dut_w (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .ewreg(1'b1), .em2reg(1'b0), .ewmem(1'b0),
        .edest_reg(w_edest), .r(w_r), .eqb(w_eqb),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .mwreg(w_mwreg), .mm2reg(w_mm2reg), .mwmem(w_mwmem),
        .mdest_reg(w_mdest), .mr(w_mr), .mqb(w_mqb)
`ifdef EXMEM_PERF_CNT_EN
        , .stall_cycles(w_stall), .bubble_cycles(w_bubble)
`endif
    );

    task automatic drive(input logic v, input ent_t e);
        in_valid  = v;
        ewreg     = e.wreg;
        em2reg    = e.m2reg;
        ewmem     = e.wmem;
        edest_reg = e.dest;
        r         = e.r;
        eqb       = e.qb;
    endtask

    function automatic ent_t mk(input logic [31:0] rv);
        ent_t e;
        e.wreg = 1'b1; e.m2reg = 1'b0; e.wmem = 1'b1;
        e.dest = rv[4:0]; e.r = rv; e.qb = ~rv;
        return e;
    endfunction

    task automatic test_reset;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++; if (mr !== 32'h0 || mwreg !== 1'b0) begin errors++; $display("FAIL reset_data got mr=%h mwreg=%0b exp 0", mr, mwreg); end
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_streaming;
        logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        @(negedge clock);
        out_ready = 1'b1;
        drive(1'b1, mk(vals[0]));
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || mr !== vals[i-1]) begin
                errors++; $display("FAIL stream_%0d got valid=%0b mr=%h exp valid=1 mr=%h", i, out_valid, mr, vals[i-1]);
            end
            if (i < 3) drive(1'b1, mk(vals[i])); else drive(1'b0, mk(0));
        end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got valid=%0b exp=0", out_valid); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, mk(32'hA));
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got=%0b exp=1", in_ready); end
        drive(1'b1, mk(32'hB));
        @(negedge clock);
        drive(1'b0, mk(0));
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%0b exp=0", in_ready); end
        checks++; if (mr !== 32'hA) begin errors++; $display("FAIL bp_hold_a got=%h exp=a", mr); end
        @(negedge clock);
        checks++; if (mr !== 32'hA || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable got mr=%h v=%0b exp a/1", mr, out_valid); end
        out_ready = 1'b1;
        @(negedge clock);
        checks++; if (mr !== 32'hB || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second got mr=%h v=%0b exp b/1", mr, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen got=%0b exp=1", in_ready); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got valid=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, mk(32'h1));
        @(negedge clock);
        drive(1'b1, mk(32'h2));
        @(negedge clock);
        flush = 1'b1;
        drive(1'b1, mk(32'hC));
        @(negedge clock);
        flush = 1'b0;
        drive(1'b0, mk(0));
        checks++; if (out_valid !== 1'b0 || mwmem !== 1'b0 || mwreg !== 1'b0) begin
            errors++; $display("FAIL flush_full got v=%0b wmem=%0b wreg=%0b exp 0", out_valid, mwmem, mwreg);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0b exp=1", in_ready); end
        out_ready = 1'b1;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got valid=%0b mr=%h exp=0", out_valid, mr); end
        // Flush with only main occupied and a live input transfer.
        out_ready = 1'b0;
        drive(1'b1, mk(32'hD));
        @(negedge clock);
        flush = 1'b1;
        drive(1'b1, mk(32'hC));
        @(negedge clock);
        flush = 1'b0;
        drive(1'b0, mk(0));
        checks++; if (out_valid !== 1'b0 || mwmem !== 1'b0) begin errors++; $display("FAIL flush_accept got v=%0b wmem=%0b exp 0", out_valid, mwmem); end
    endtask

    task automatic test_widths;
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_r         = 64'hFFFF_0000_1234_5678;
        w_eqb       = 64'h0123_4567_89AB_CDEF;
        w_edest     = 6'd63;
        @(negedge clock);
        w_in_valid = 1'b0;
        checks++;
        if (w_out_valid !== 1'b1 || w_mr !== 64'hFFFF_0000_1234_5678 || w_mdest !== 6'd63 || w_mqb !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL wide_payload got v=%0b mr=%h dest=%0d qb=%h", w_out_valid, w_mr, w_mdest, w_mqb);
        end
        checks++; if (w_mwreg !== 1'b1) begin errors++; $display("FAIL wide_wreg got=%0b exp=1", w_mwreg); end
    endtask

    task automatic test_random;
        ent_t mq[$];
        ent_t p, got;
        logic iv, ord, fl;
        @(negedge clock);
        flush = 1'b1; in_valid = 1'b0;
        @(negedge clock);
        flush = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            got = '{mwreg, mm2reg, mwmem, mdest_reg, mr, mqb};
            checks++;
            if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, out_valid, mq.size() > 0); end
            checks++;
            if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, in_ready, mq.size() < 2); end
            checks++;
            if (mq.size() > 0) begin
                if (got !== mq[0]) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, got, mq[0]); end
            end else if (mwreg !== 1'b0 || mwmem !== 1'b0) begin
                errors++; $display("FAIL rnd_qual c=%0d got wreg=%0b wmem=%0b exp 0", c, mwreg, mwmem);
            end
            iv  = ($urandom % 4) != 0;
            ord = ($urandom % 3) != 0;
            fl  = ($urandom % 16) == 0;
            p   = {$urandom, $urandom, $urandom};
            drive(iv, p);
            out_ready = ord;
            flush     = fl;
            if (fl) mq.delete();
            else begin
                logic push;
                push = iv && (mq.size() < 2);
                if (mq.size() > 0 && ord) void'(mq.pop_front());
                if (push) mq.push_back(p);
            end
        end
        @(negedge clock);
        flush = 1'b1; in_valid = 1'b0;
        @(negedge clock);
        flush = 1'b0;
    endtask

`ifdef EXMEM_PERF_CNT_EN
    task automatic test_perf;
        logic [31:0] s0, b0;
        out_ready = 1'b0;
        drive(1'b1, mk(32'h5));
        @(negedge clock);
        drive(1'b0, mk(0));
        s0 = stall_cycles; b0 = bubble_cycles;
        repeat (3) @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        repeat (2) @(negedge clock);
        checks++; if (stall_cycles - s0 !== 32'd3) begin errors++; $display("FAIL perf_stall got=%0d exp=3", stall_cycles - s0); end
        checks++; if (bubble_cycles - b0 !== 32'd2) begin errors++; $display("FAIL perf_bubble got=%0d exp=2", bubble_cycles - b0); end
    endtask
`endif

    task automatic test_reset_midstream;
        @(negedge clock);
        out_ready = 1'b0;
        drive(1'b1, mk(32'h77));
        @(negedge clock);
        drive(1'b1, mk(32'h88));
        @(negedge clock);
        drive(1'b0, mk(0));
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_fill got rdy=%0b v=%0b exp 0/1", in_ready, out_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || mr !== 32'h0 || mwreg !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v=%0b mr=%h wreg=%0b rdy=%0b exp all 0", out_valid, mr, mwreg, in_ready);
        end
`ifdef EXMEM_PERF_CNT_EN
        checks++; if (stall_cycles !== 32'd0 || bubble_cycles !== 32'd0) begin errors++; $display("FAIL mid_perf_clear got s=%0d b=%0d exp 0", stall_cycles, bubble_cycles); end
`endif
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release got rdy=%0b v=%0b exp 1/0", in_ready, out_valid); end
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_backpressure;
        test_flush;
        test_widths;
        test_random;
`ifdef EXMEM_PERF_CNT_EN
        test_perf;
`endif
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exmem_pipeline_stage.md
Name: exmem_pipeline_stage

Overview:
Parametrised EX/MEM pipeline stage: successor to the fixed 32-bit EX/MEM register. Adds a valid/ready handshake with a 2-entry skid buffer, so the stage can stall without a combinational ready path back into EX. Adds a synchronous flush for branch/exception squash, and parametrised data and register-address widths. Sits between the ALU/execute stage and the data-memory stage.

Parameters:
DATA_W, 32, width of the ALU result (r/mr) and store data (eqb/mqb)
REG_ADDR_W, 5, width of the destination register index

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash of all held and incoming entries
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept; registered, no combinational path from out_ready
ewreg  in  1  EX register-write enable
em2reg  in  1  EX memory-to-register select
ewmem  in  1  EX memory-write enable
edest_reg  in  REG_ADDR_W  EX destination register
r  in  DATA_W  EX ALU result
eqb  in  DATA_W  EX store data
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM stage accepts
mwreg  out  1  register-write enable, qualified: 0 when out_valid=0
mm2reg  out  1  memory-to-register select
mwmem  out  1  memory-write enable, qualified: 0 when out_valid=0
mdest_reg  out  REG_ADDR_W  destination register
mr  out  DATA_W  ALU result
mqb  out  DATA_W  store data

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is high, all entries are invalid, every output and data register is 0, and in_ready=0. The first edge after deassertion sees in_ready=1.
- Storage: main entry (drives outputs) plus skid entry. Payload = {ewreg, em2reg, ewmem, edest_reg, r, eqb}.
- Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
- in_ready = !skid_valid, registered.
- Main empty, or main leaving this cycle, with skid empty: input goes to main. Latency 1 cycle.
- Main valid and not leaving: input goes to skid. in_ready drops next cycle.
- Main leaving and skid valid: skid moves to main. An input in the same cycle is impossible, since in_ready=0.
- Full (both valid, out_ready=0): hold everything. Data held bit-stable while out_valid && !out_ready.
- Simultaneous input and output transfer with skid empty: main is replaced. Throughput is 1 per cycle and out_valid stays 1.
- flush=1: both valid bits clear at the edge. The input that cycle is discarded even if in_valid && in_ready. Payload registers may keep stale data, but mwreg/mwmem read 0 via qualification. flush has priority over all transfers; reset has priority over flush.
- Order is preserved: no entry is dropped or duplicated except by flush.
- Only the main and skid registers; no arithmetic.

Optional Feature:
Macro EXMEM_PERF_CNT_EN.
- Defined: adds output ports stall_cycles[31:0] and bubble_cycles[31:0].
  - stall_cycles increments when out_valid && !out_ready.
  - bubble_cycles increments when !out_valid && !reset.
  - Both wrap at 2^32-1 -> 0, are cleared by reset, and are not cleared by flush.
- Undefined: the ports and logic are absent. Handshake behaviour is identical in both builds.

Decomposition:
- Package exmem_pkg: exmem_ctrl_t packed struct {wreg, m2reg, wmem}; default widths DATA_W_DEF=32, REG_ADDR_W_DEF=5; payload-width function.
- One sub-module, pipe_skid_buffer (parameter PAYLOAD_W). It is a generic 2-entry valid/ready skid buffer with flush. exmem_pipeline_stage packs the payload into it, unpacks it, and applies mwreg/mwmem qualification and the perf counters.

Test Plan:
- Reset mid-stream: both entries full, assert reset -> out_valid=0, mr=0, mwreg=0, in_ready=0 immediately; in_ready=1 after release.
- Streaming: out_ready=1, inputs r=0x11,0x22,0x33 on consecutive cycles -> mr=0x11,0x22,0x33 one cycle later each, out_valid continuously 1.
- Backpressure: out_ready=0, send r=0xA then 0xB -> in_ready=0 after the second transfer, mr holds 0xA. Raise out_ready -> 0xA then 0xB, no loss, no duplicate.
- Flush while full plus in_valid: flush=1 with r=0xC presented -> next cycle out_valid=0, mwmem=0, 0xC never appears.
- Widths: DATA_W=64, REG_ADDR_W=6; send r=0xFFFF_0000_1234_5678, edest_reg=63 -> mr and mdest_reg match exactly.
- EXMEM_PERF_CNT_EN: 3 cycles of out_valid && !out_ready, then 2 empty cycles -> stall_cycles=3, bubble_cycles=2.
